// File: rtl/mult_accum_if.sv
// Handshake bundle between the multiplier output, the accumulator and the sum consumer.
// The master side drives products and control; the slave side returns the accumulated sum.
interface mult_accum_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int ACC_W = 2*WIDTH+2
);
  // start/len are sampled only in IDLE. Each rising edge of the level-type p_rdy delivers one product p.
  // sum_valid stays high, with sum held, until the cycle that sees sum_ack.
  logic                  start;
  logic [CNT_W-1:0]      len;
  logic [2*WIDTH-1:0]    p;
  logic                  p_rdy;
  logic [ACC_W-1:0]      sum;
  logic                  sum_valid;
  logic                  sum_ack;
  logic                  ovf;
  logic                  busy;
  logic [CNT_W-1:0]      count;
  logic [1:0]            dbg_state;

  modport master (
    output start, len, p, p_rdy, sum_ack,
    input  sum, sum_valid, ovf, busy, count, dbg_state
  );

  modport slave (
    input  start, len, p, p_rdy, sum_ack,
    output sum, sum_valid, ovf, busy, count, dbg_state
  );
endinterface

// File: rtl/mult_accum.sv
// Dot-product accumulator: sums a programmed number of signed products, one per p_rdy rise,
// and presents the wrapped sum with a sticky signed-overflow flag.
module mult_accum #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int ACC_W = 2*WIDTH+2
) (
  input  logic         clk,
  input  logic         reset,
  mult_accum_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_DONE = 2'd2} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [ACC_W-1:0]   r_sum;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_len;
  logic               r_ovf;
  logic               r_p_rdy_q;

  logic               w_cap;
  logic [ACC_W-1:0]   w_addend;
  logic [ACC_W-1:0]   w_sum_next;
  logic               w_add_ovf;
  logic [CNT_W-1:0]   w_count_inc;
  logic               w_sum_valid;
  logic               w_busy;

  // p_rdy is a level that stays high, so only its rising edge counts as a new product.
  assign w_cap       = bus.p_rdy & ~r_p_rdy_q;
  assign w_addend    = {{(ACC_W-2*WIDTH){bus.p[2*WIDTH-1]}}, bus.p};
  assign w_sum_next  = r_sum + w_addend;
  assign w_add_ovf   = (w_addend[ACC_W-1] == r_sum[ACC_W-1]) &&
                       (w_sum_next[ACC_W-1] != r_sum[ACC_W-1]);
  assign w_count_inc = r_count + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next_state = (bus.len == '0) ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        if (w_cap && (w_count_inc == r_len)) w_next_state = S_DONE;
      end
      S_DONE: begin
        if (bus.sum_ack) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_sum_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_ACCUM: w_busy = 1'b1;
      S_DONE: begin
        w_busy      = 1'b1;
        w_sum_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: cleared on an accepted start, updated per capture, frozen otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum     <= '0;
      r_count   <= '0;
      r_len     <= '0;
      r_ovf     <= 1'b0;
      r_p_rdy_q <= 1'b0;
    end else begin
      r_p_rdy_q <= bus.p_rdy;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sum   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_len   <= bus.len;
          end
        end
        S_ACCUM: begin
          if (w_cap) begin
            r_sum   <= w_sum_next;
            r_count <= w_count_inc;
            r_ovf   <= r_ovf | w_add_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum       = r_sum;
  assign bus.count     = r_count;
  assign bus.ovf       = r_ovf;
  assign bus.sum_valid = w_sum_valid;
  assign bus.busy      = w_busy;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mult_accum.sv
// Self-checking bench for mult_accum: directed scenarios plus a randomized model-driven pass,
// with expected sums queued at stimulus time and popped when sum_valid appears.
module tb_mult_accum;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int ACC_W = 2*WIDTH+2;
  localparam longint ACC_MAX = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W-1));

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [ACC_W-1:0] exp_q[$];

  mult_accum_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();

  mult_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: each returns 1 time unit after a rising edge
  task automatic do_start(input int l);
    bus.start = 1'b1;
    bus.len   = CNT_W'(l);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_product(input int v);
    @(posedge clk); #1;
    bus.p     = 16'(v);
    bus.p_rdy = 1'b1;
    @(posedge clk); #1;
    bus.p_rdy = 1'b0;
  endtask

  task automatic do_ack();
    bus.sum_ack = 1'b1;
    @(posedge clk); #1;
    bus.sum_ack = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.sum_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.p = '0; bus.p_rdy = 1'b0; bus.sum_ack = 1'b0;
    #3;
    checks++;
    if (bus.sum !== '0 || bus.count !== '0 || bus.ovf !== 1'b0 ||
        bus.sum_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: sum=%0d count=%0d ovf=%b valid=%b busy=%b, expected all zero",
               bus.sum, bus.count, bus.ovf, bus.sum_valid, bus.busy);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit got;
    logic [ACC_W-1:0] exp;
    exp_q.push_back(ACC_W'(157));
    do_start(3);
    send_product(200);
    send_product(-50);
    checks++;
    if (bus.sum_valid !== 1'b0 || bus.count !== 4'd2) begin
      failures++;
      $display("FAIL basic_mid: valid=%b count=%0d, expected valid=0 count=2", bus.sum_valid, bus.count);
    end
    send_product(7);
    checks++;
    if (bus.sum_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency: valid=%b one cycle after last capture, expected 1", bus.sum_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    wait_valid(got);
    checks++;
    if (!got || exp_q.size() == 0) begin
      failures++;
      $display("FAIL basic_hold: valid=%b queue=%0d, expected valid held", bus.sum_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if (bus.sum !== exp || bus.count !== 4'd3 || bus.ovf !== 1'b0) begin
        failures++;
        $display("FAIL basic_sum: sum=%0d count=%0d ovf=%b, expected sum=%0d count=3 ovf=0",
                 $signed(bus.sum), bus.count, bus.ovf, $signed(exp));
      end
    end
    do_ack();
    checks++;
    if (bus.sum_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_ack: valid=%b busy=%b, expected 0 0", bus.sum_valid, bus.busy);
    end
  endtask

  task automatic test_held_rdy();
    bit got;
    logic [ACC_W-1:0] exp;
    exp_q.push_back(ACC_W'(7));
    do_start(2);
    bus.p = 16'(10);
    bus.p_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.p_rdy = 1'b0;
    checks++;
    if (bus.count !== 4'd1 || bus.sum_valid !== 1'b0) begin
      failures++;
      $display("FAIL held_rdy_single: count=%0d valid=%b, expected count=1 valid=0", bus.count, bus.sum_valid);
    end
    send_product(-3);
    wait_valid(got);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL held_rdy_timeout: valid=%b, expected 1", bus.sum_valid);
    end else begin
      exp = exp_q.pop_front();
      if (bus.sum !== exp || bus.count !== 4'd2) begin
        failures++;
        $display("FAIL held_rdy_sum: sum=%0d count=%0d, expected sum=%0d count=2",
                 $signed(bus.sum), bus.count, $signed(exp));
      end
    end
    do_ack();
  endtask

  task automatic test_len_zero();
    do_start(0);
    checks++;
    if (bus.sum_valid !== 1'b1 || bus.sum !== '0 || bus.count !== '0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL len_zero: valid=%b sum=%0d count=%0d busy=%b, expected 1 0 0 1",
               bus.sum_valid, $signed(bus.sum), bus.count, bus.busy);
    end
    do_ack();
  endtask

  task automatic test_overflow();
    bit got;
    logic [ACC_W-1:0] exp;
    exp_q.push_back(ACC_W'(-114688));
    do_start(9);
    for (int i = 1; i <= 9; i++) begin
      send_product(16384);
      if (i == 7) begin
        checks++;
        if (bus.ovf !== 1'b0) begin
          failures++;
          $display("FAIL ovf_early: ovf=%b after 7 captures, expected 0", bus.ovf);
        end
      end
      if (i == 8) begin
        checks++;
        if (bus.ovf !== 1'b1) begin
          failures++;
          $display("FAIL ovf_set: ovf=%b after 8 captures, expected 1", bus.ovf);
        end
      end
    end
    wait_valid(got);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL ovf_timeout: valid=%b, expected 1", bus.sum_valid);
    end else begin
      exp = exp_q.pop_front();
      if (bus.sum !== exp || bus.ovf !== 1'b1 || bus.count !== 4'd9) begin
        failures++;
        $display("FAIL ovf_sum: sum=%0d ovf=%b count=%0d, expected sum=%0d ovf=1 count=9",
                 $signed(bus.sum), bus.ovf, bus.count, $signed(exp));
      end
    end
    do_ack();
    checks++;
    if (bus.ovf !== 1'b1 || bus.sum !== ACC_W'(-114688)) begin
      failures++;
      $display("FAIL ovf_retain: ovf=%b sum=%0d in IDLE, expected ovf=1 sum=-114688", bus.ovf, $signed(bus.sum));
    end
  endtask

  task automatic test_async_reset();
    bit got;
    logic [ACC_W-1:0] exp;
    do_start(4);
    checks++;
    if (bus.ovf !== 1'b0 || bus.sum !== '0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL start_clears: ovf=%b sum=%0d busy=%b, expected 0 0 1", bus.ovf, $signed(bus.sum), bus.busy);
    end
    send_product(100);
    send_product(100);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.sum !== '0 || bus.count !== '0 || bus.busy !== 1'b0 || bus.sum_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: sum=%0d count=%0d busy=%b valid=%b, expected all zero",
               $signed(bus.sum), bus.count, bus.busy, bus.sum_valid);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(ACC_W'(-5));
    do_start(1);
    send_product(-5);
    wait_valid(got);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL post_reset_timeout: valid=%b, expected 1", bus.sum_valid);
    end else begin
      exp = exp_q.pop_front();
      if (bus.sum !== exp || bus.count !== 4'd1) begin
        failures++;
        $display("FAIL post_reset_sum: sum=%0d count=%0d, expected sum=%0d count=1",
                 $signed(bus.sum), bus.count, $signed(exp));
      end
    end
    do_ack();
  endtask

  task automatic test_done_start();
    bit got;
    logic [ACC_W-1:0] exp;
    do_start(1);
    send_product(42);
    bus.start = 1'b1;
    bus.len   = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.sum_valid !== 1'b1 || bus.sum !== ACC_W'(42) || bus.count !== 4'd1) begin
        failures++;
        $display("FAIL done_start_hold: valid=%b sum=%0d count=%0d, expected 1 42 1",
                 bus.sum_valid, $signed(bus.sum), bus.count);
      end
    end
    do_ack();
    checks++;
    if (bus.sum_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL done_ack_with_start: valid=%b busy=%b, expected 0 0", bus.sum_valid, bus.busy);
    end
    exp_q.push_back(ACC_W'(-1000 + 3));
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.sum !== '0 || bus.count !== '0) begin
      failures++;
      $display("FAIL restart: busy=%b sum=%0d count=%0d, expected 1 0 0", bus.busy, $signed(bus.sum), bus.count);
    end
    send_product(-1000);
    send_product(3);
    wait_valid(got);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL restart_timeout: valid=%b, expected 1", bus.sum_valid);
    end else begin
      exp = exp_q.pop_front();
      if (bus.sum !== exp || bus.count !== 4'd2) begin
        failures++;
        $display("FAIL restart_sum: sum=%0d count=%0d, expected sum=%0d count=2",
                 $signed(bus.sum), bus.count, $signed(exp));
      end
    end
    do_ack();
  endtask

  task automatic test_random();
    bit got;
    logic [ACC_W-1:0] exp;
    for (int r = 0; r < 8; r++) begin
      int     l;
      int     pv[];
      longint acc;
      bit     m_ovf;
      l     = $urandom_range(1, 15);
      pv    = new[l];
      acc   = 0;
      m_ovf = 1'b0;
      for (int k = 0; k < l; k++) begin
        pv[k] = int'($urandom_range(0, 32640)) - 16256;
        acc   = acc + pv[k];
        if (acc > ACC_MAX) begin
          acc = acc - (64'sd1 <<< ACC_W);
          m_ovf = 1'b1;
        end else if (acc < ACC_MIN) begin
          acc = acc + (64'sd1 <<< ACC_W);
          m_ovf = 1'b1;
        end
      end
      exp_q.push_back(ACC_W'(acc));
      do_start(l);
      for (int k = 0; k < l; k++) send_product(pv[k]);
      wait_valid(got);
      checks++;
      if (!got || exp_q.size() == 0) begin
        failures++;
        $display("FAIL rand_timeout: round=%0d valid=%b, expected 1", r, bus.sum_valid);
      end else begin
        exp = exp_q.pop_front();
        if (bus.sum !== exp || bus.ovf !== m_ovf || bus.count !== CNT_W'(l)) begin
          failures++;
          $display("FAIL rand_sum: round=%0d sum=%0d ovf=%b count=%0d, expected sum=%0d ovf=%b count=%0d",
                   r, $signed(bus.sum), bus.ovf, bus.count, $signed(exp), m_ovf, l);
        end
      end
      do_ack();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_rdy();
    test_len_zero();
    test_overflow();
    test_async_reset();
    test_done_start();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
